max7219_display_ctrl: RTL
=========================

Name: max7219_display_ctrl

Overview:
- Sequencer that drives the MAX7219 SPI driver (start/busy, addr/data handshake).
- After reset, issues the chip init sequence, then keeps the 8 digit registers coherent with a local 8x8-bit framebuffer.
- Pushes intensity changes to the chip.
- Sits between the application logic (framebuffer writes, intensity control) and the MAX7219 driver instance.

Parameters:
DECODE_MODE, 8'h00, value written to reg 0x09 during init
SCAN_LIMIT, 3'd7, value written to reg 0x0B during init
INIT_INTENSITY, 4'h8, intensity used during init and held until the intensity input first differs
GAP_CYCLES, 4, idle clk cycles inserted after each transfer completes (CS high time); range 1..255
ACK_TIMEOUT, 16, max cycles to wait for drv_busy to rise after drv_start

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
drv_start  out  1  one-cycle start pulse to driver
drv_addr  out  8  register address to driver, stable from start pulse until transfer done
drv_data  out  8  register data to driver, same stability rule
drv_busy  in  1  driver busy
fb_we  in  1  framebuffer write strobe
fb_waddr  in  3  digit index 0..7 (chip reg 0x01..0x08)
fb_wdata  in  8  digit segment/code data
intensity  in  4  requested intensity, sampled every cycle
init_done  out  1  high once init sequence completed
idle  out  1  high when no transfer pending or in flight and init done
err  out  1  sticky: drv_busy never rose within ACK_TIMEOUT; cleared only by rst

Behaviour:
- Reset values:
  - drv_start=0, drv_addr=0, drv_data=0, init_done=0, idle=0, err=0.
  - fb all 0; dirty mask=8'hFF so all digits refresh after init.
  - last_int=INIT_INTENSITY; rr pointer=0; state=SEL; init index=0.
- Reset mid-transfer: controller returns to SEL and restarts init from step 0. The driver shares rst.
- Init sequence, in order, one transfer each:
  - (0x0C,0x00)
  - (0x0F,0x00)
  - (0x09,DECODE_MODE)
  - (0x0B,{5'b0,SCAN_LIMIT})
  - (0x0A,{4'b0,INIT_INTENSITY})
  - (0x0C,0x01)
  - init_done rises in the cycle after the 6th transfer's GAP ends.
- States:
  - SEL: pick the next job; go to ISSUE if a job exists.
  - ISSUE: drv_start=1 for exactly one cycle, addr/data already loaded; go to ACK.
  - ACK: wait for drv_busy=1, then go to DONE. After ACK_TIMEOUT cycles without it, set err and go to GAP; the job counts as consumed.
  - DONE: wait for drv_busy=0, then go to GAP.
  - GAP: count GAP_CYCLES, then go to SEL.
- Job selection in SEL, after init_done:
  - Priority 1: intensity != last_int. Send (0x0A,{4'b0,intensity}) and set last_int=intensity at ISSUE.
  - Priority 2: any dirty bit set. Round-robin from rr: choose the first dirty index i at or after rr (mod 8), send (i+1, fb[i]), clear dirty[i] at ISSUE, set rr=i+1 mod 8.
  - Otherwise stay in SEL with idle=1.
- Before init_done, dirty and intensity jobs wait. Framebuffer writes are still accepted and mark dirty.
- Framebuffer writes:
  - fb_we writes fb[fb_waddr]=fb_wdata and sets dirty[fb_waddr] in any state, one-cycle effect.
  - Write to index i in the same cycle ISSUE clears dirty[i]: write wins, dirty stays 1. The in-flight transfer carries the old data latched at SEL; the new data goes out on a later transfer.
- Intensity changes during a transfer are picked up at the next SEL. Multiple changes coalesce, so only the latest value is sent.
- drv_addr/drv_data are registered, loaded in SEL, and held until the next SEL load.
- idle=1 only in SEL with init_done=1 and no job pending.
- Latency, write to chip: fb_we at cycle t, controller idle → SEL registers the job at t+1, drv_start at t+2.

Test Plan:
- Reset release, driver model with busy 1 cycle after start and 16-cycle transfers → exactly 6 transfers (0C/00, 0F/00, 09/00, 0B/07, 0A/08, 0C/01), then 8 digit transfers addr 01..08 with data 00. Each drv_start is a single cycle; each gap is ≥4 cycles. Then idle=1.
- After idle, fb_we idx 5 data 8'hA5 → single transfer (0x06,0xA5), start 2 cycles after the write, then idle=1.
- During a digit transfer, intensity 8→3 then 3→C and idx 2 written → next transfer (0x0A,0x0C) only, no 0x03 sent, then (0x03,data).
- Write idx 0 with 0x11 in the cycle ISSUE sends idx 0 with old 0x22 → (0x01,0x22) then (0x01,0x11).
- Dirty idx 1,6 with rr=3 → order 0x07 then 0x02.
- Driver busy stuck 0 → after 16 cycles in ACK err=1, sequence continues. rst asserted mid-DONE → all outputs at reset values next cycle, init restarts at (0x0C,0x00), err=0.

Source files
------------

// File: rtl/max7219_display_ctrl.sv
// -----------------------------------------------------------------------------
// max7219_display_ctrl
//
// Sequencer sitting between application logic and a MAX7219 SPI driver.
// After reset it runs the chip init sequence, then keeps the eight digit
// registers coherent with a local 8x8-bit framebuffer and pushes intensity
// changes to the chip.
//
// Driver handshake: drv_start is a single-cycle pulse, issued with drv_addr
// and drv_data already registered. The driver acknowledges by raising
// drv_busy and completes the transfer by dropping it. drv_addr/drv_data stay
// stable from the pulse until the next job is selected, which only happens
// after the transfer and the trailing idle gap have finished. If drv_busy
// never rises within ACK_TIMEOUT cycles, err latches and the job is dropped.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   drv_start           one-cycle start pulse to the driver
//   drv_addr, drv_data  register address / data for the driver
//   drv_busy            driver busy
//   fb_we, fb_waddr,
//   fb_wdata            framebuffer write port (digit 0..7 -> chip reg 1..8)
//   intensity           requested intensity, sampled every cycle
//   init_done           init sequence completed
//   idle                nothing pending or in flight, init done
//   err                 sticky driver acknowledge timeout
// -----------------------------------------------------------------------------
module max7219_display_ctrl #(
    parameter logic [7:0]  DECODE_MODE    = 8'h00,
    parameter logic [2:0]  SCAN_LIMIT     = 3'd7,
    parameter logic [3:0]  INIT_INTENSITY = 4'h8,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned ACK_TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       drv_start,
    output logic [7:0] drv_addr,
    output logic [7:0] drv_data,
    input  logic       drv_busy,
    input  logic       fb_we,
    input  logic [2:0] fb_waddr,
    input  logic [7:0] fb_wdata,
    input  logic [3:0] intensity,
    output logic       init_done,
    output logic       idle,
    output logic       err
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);
    localparam logic [2:0]  INIT_STEPS = 3'd6;

    typedef enum logic [2:0] {
        ST_SEL,
        ST_ISSUE,
        ST_ACK,
        ST_DONE,
        ST_GAP
    } state_t;

    typedef enum logic [1:0] {
        JOB_INIT,
        JOB_INT,
        JOB_DIGIT
    } job_t;

    state_t           state;
    state_t           state_next;
    logic [7:0][7:0]  fb;
    logic [7:0]       dirty;
    logic [7:0]       dirty_next;
    logic [3:0]       last_int;
    logic [2:0]       rr;
    logic [2:0]       init_idx;
    logic [15:0]      cnt;
    job_t             job_kind;
    logic [2:0]       job_idx;

    logic             rr_found;
    logic [2:0]       rr_idx;
    logic [2:0]       cand;
    logic             job_avail;
    job_t             sel_kind;
    logic [7:0]       sel_addr;
    logic [7:0]       sel_data;

    function automatic logic [15:0] init_word(input logic [2:0] i);
        case (i)
            3'd0:    return {8'h0C, 8'h00};
            3'd1:    return {8'h0F, 8'h00};
            3'd2:    return {8'h09, DECODE_MODE};
            3'd3:    return {8'h0B, 5'b0, SCAN_LIMIT};
            3'd4:    return {8'h0A, 4'b0, INIT_INTENSITY};
            default: return {8'h0C, 8'h01};
        endcase
    endfunction

    // First dirty digit at or after the round-robin pointer, wrapping mod 8.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr;
        cand     = rr;
        for (int k = 0; k < 8; k++) begin
            cand = rr + 3'(k);
            if (!rr_found && dirty[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // Job selection: init steps first, then intensity, then dirty digits.
    always_comb begin
        job_avail = 1'b0;
        sel_kind  = JOB_INIT;
        sel_addr  = 8'h00;
        sel_data  = 8'h00;
        if (!init_done) begin
            if (init_idx < INIT_STEPS) begin
                job_avail            = 1'b1;
                sel_kind             = JOB_INIT;
                {sel_addr, sel_data} = init_word(init_idx);
            end
        end else if (intensity != last_int) begin
            job_avail = 1'b1;
            sel_kind  = JOB_INT;
            sel_addr  = 8'h0A;
            sel_data  = {4'b0, intensity};
        end else if (rr_found) begin
            job_avail = 1'b1;
            sel_kind  = JOB_DIGIT;
            sel_addr  = {5'b0, rr_idx} + 8'd1;
            // A write to the chosen digit in this very cycle would otherwise be
            // lost: its dirty bit gets cleared at ISSUE. Forward the new byte.
            sel_data  = (fb_we && fb_waddr == rr_idx) ? fb_wdata : fb[rr_idx];
        end
    end

    always_comb begin
        state_next = state;
        drv_start  = 1'b0;
        idle       = 1'b0;
        case (state)
            ST_SEL: begin
                idle = init_done && !job_avail;
                if (job_avail) state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                drv_start  = 1'b1;
                state_next = ST_ACK;
            end
            ST_ACK: begin
                if (drv_busy)             state_next = ST_DONE;
                else if (cnt == ACK_LAST) state_next = ST_GAP;
            end
            ST_DONE: begin
                if (!drv_busy) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (cnt == GAP_LAST) state_next = ST_SEL;
            end
            default: state_next = ST_SEL;
        endcase
    end

    // A framebuffer write sets its dirty bit after the ISSUE clear, so a
    // write racing the issue of the same digit keeps it queued.
    always_comb begin
        dirty_next = dirty;
        if (state == ST_ISSUE && job_kind == JOB_DIGIT) dirty_next[job_idx] = 1'b0;
        if (fb_we) dirty_next[fb_waddr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SEL;
            drv_addr  <= 8'h00;
            drv_data  <= 8'h00;
            init_done <= 1'b0;
            err       <= 1'b0;
            fb        <= '0;
            dirty     <= 8'hFF;
            last_int  <= INIT_INTENSITY;
            rr        <= 3'd0;
            init_idx  <= 3'd0;
            cnt       <= 16'd0;
            job_kind  <= JOB_INIT;
            job_idx   <= 3'd0;
        end else begin
            state <= state_next;
            // cnt measures cycles spent in the current state.
            cnt   <= (state != state_next) ? 16'd0 : cnt + 16'd1;

            if (state == ST_SEL && job_avail) begin
                drv_addr <= sel_addr;
                drv_data <= sel_data;
                job_kind <= sel_kind;
                job_idx  <= rr_idx;
            end

            if (state == ST_ISSUE) begin
                case (job_kind)
                    JOB_INIT:  init_idx <= init_idx + 3'd1;
                    // Use the value actually sent; a change after SEL is
                    // picked up by the next selection.
                    JOB_INT:   last_int <= drv_data[3:0];
                    JOB_DIGIT: rr       <= job_idx + 3'd1;
                    default:   ;
                endcase
            end

            if (state == ST_ACK && !drv_busy && cnt == ACK_LAST) err <= 1'b1;

            if (state == ST_GAP && cnt == GAP_LAST && !init_done && init_idx == INIT_STEPS)
                init_done <= 1'b1;

            if (fb_we) fb[fb_waddr] <= fb_wdata;
            dirty <= dirty_next;
        end
    end

endmodule
